bmult_limb_seq: RTL and testbench

BMULT_LIMB_SEQ -- requirements
Module: bmult_limb_seq

---
 rtl/bmult_pkg.sv | 29 ++
 rtl/Bmult26x26.sv | 24 ++
 rtl/bmult_limb_seq.sv | 147 ++++++++++++++
 tb/tb_bmult_limb_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bmult_pkg.sv
// Shared widths, FSM state encoding and partial-product alignment for the
// limb-sequential 52x52 multiplier.
package bmult_pkg;

   localparam int LIMB_W = 26;
   localparam int PROD_W = 2 * LIMB_W;
   localparam int OPND_W = 2 * LIMB_W;
   localparam int RES_W  = 4 * LIMB_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Index 0 is a0*b0, 1 and 2 are the cross terms, 3 is a1*b1.
   function automatic logic [RES_W-1:0] place_partial(input logic [PROD_W-1:0] p,
                                                      input logic [1:0]        idx);
      logic [RES_W-1:0] ext;
      ext = RES_W'(p);
      case (idx)
         2'd0:    place_partial = ext;
         2'd3:    place_partial = ext << (2 * LIMB_W);
         default: place_partial = ext << LIMB_W;
      endcase
   endfunction

endpackage

// File: rtl/Bmult26x26.sv
// Single-stage 26x26 unsigned multiplier; product registered once, no reset.
module Bmult26x26
   import bmult_pkg::*;
(
   input  logic              clk,
   input  logic [LIMB_W-1:0] a,
   input  logic [LIMB_W-1:0] b,
   output logic [PROD_W-1:0] p
);

   logic [PROD_W-1:0] p_d;
   logic [PROD_W-1:0] p_q;

   always_comb begin
      p_d = PROD_W'(a) * PROD_W'(b);
   end

   always_ff @(posedge clk) begin
      p_q <= p_d;
   end

   assign p = p_q;

endmodule

// File: rtl/bmult_limb_seq.sv
// 52x52 unsigned multiplier built from four passes through one 26x26 unit,
// with valid/ready handshakes on both sides and a 6-cycle acceptance latency.
module bmult_limb_seq
   import bmult_pkg::state_e;
   import bmult_pkg::ST_IDLE;
   import bmult_pkg::ST_ISSUE;
   import bmult_pkg::ST_DRAIN;
   import bmult_pkg::ST_DONE;
   import bmult_pkg::PROD_W;
   import bmult_pkg::place_partial;
#(
   parameter int LIMB_W = 26
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*LIMB_W-1:0]   in_a,
   input  logic [2*LIMB_W-1:0]   in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*LIMB_W-1:0]   out_p,
   output logic                  busy
);

   localparam int OPND_W = 2 * LIMB_W;
   localparam int RES_W  = 4 * LIMB_W;

   state_e             state_q, state_d;
   logic [OPND_W-1:0]  a_q, a_d;
   logic [OPND_W-1:0]  b_q, b_d;
   logic [1:0]         idx_q, idx_d;
   logic               pend_vld_q, pend_vld_d;
   logic [1:0]         pend_idx_q, pend_idx_d;
   logic [RES_W-1:0]   acc_q, acc_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [LIMB_W-1:0]  mul_a;
   logic [LIMB_W-1:0]  mul_b;
   logic [PROD_W-1:0]  mul_p;

   Bmult26x26 u_mult (
      .clk (clk),
      .a   (mul_a),
      .b   (mul_b),
      .p   (mul_p)
   );

   // pend_* tags whatever the multiplier registered last cycle, so the
   // unreset product register never reaches the accumulator untagged.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      idx_d       = idx_q;
      pend_vld_d  = 1'b0;
      pend_idx_d  = idx_q;
      acc_d       = acc_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      mul_a       = '0;
      mul_b       = '0;

      if (pend_vld_q) begin
         acc_d = acc_q + place_partial(mul_p, pend_idx_q);
      end

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d        = in_a;
               b_d        = in_b;
               acc_d      = '0;
               idx_d      = 2'd0;
               state_d    = ST_ISSUE;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_ISSUE: begin
            mul_a      = idx_q[1] ? a_q[OPND_W-1:LIMB_W] : a_q[LIMB_W-1:0];
            mul_b      = idx_q[0] ? b_q[OPND_W-1:LIMB_W] : b_q[LIMB_W-1:0];
            pend_vld_d = 1'b1;
            pend_idx_d = idx_q;
            idx_d      = 2'(idx_q + 2'd1);
            if (idx_q == 2'd3) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         pend_vld_q  <= 1'b0;
         pend_idx_q  <= 2'd0;
         acc_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pend_vld_q  <= pend_vld_d;
         pend_idx_q  <= pend_idx_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Operand latches are only read in ISSUE, after a fresh load.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_p     = acc_q;

endmodule

// File: tb/tb_bmult_limb_seq.sv
// Bench for bmult_limb_seq: directed vector table, hold/reset sequences and
// randomized operands checked against a plain-arithmetic product model.
module tb_bmult_limb_seq;

   localparam logic [51:0]  MAX52 = 52'hFFFFFFFFFFFFF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [51:0]   in_a = '0;
   logic [51:0]   in_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [103:0]  out_p;
   logic          busy;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bmult_limb_seq #(.LIMB_W(26)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   typedef struct {
      logic [51:0]  a;
      logic [51:0]  b;
      logic [103:0] p;
      int           hold;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [103:0] ref_mul(input logic [51:0] a, input logic [51:0] b);
      return 104'(a) * 104'(b);
   endfunction

   task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [51:0] rand52();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[51:0];
   endfunction

   // One full transaction; hold = cycles out_ready stays low after out_valid.
   task automatic run_op(input logic [51:0] a, input logic [51:0] b, input int hold,
                         output logic [103:0] p, output int lat, output realtime t_acc);
      int n;
      int cyc;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_ready", 104'(in_ready), 104'(1));
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      out_ready = (hold == 0);
      @(posedge clk);
      t_acc = $realtime;
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_a     = rand52();
      in_b     = rand52();
      cyc = 1;
      chk("busy_after_accept", 104'(busy), 104'(1));
      chk("in_ready_after_accept", 104'(in_ready), 104'(0));
      while (!out_valid && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         in_valid = 1'($urandom_range(0, 1));
         in_a     = rand52();
      end
      lat = cyc;
      p   = out_p;
      for (int k = 0; k < hold; k++) begin
         chk("hold_valid", 104'(out_valid), 104'(1));
         chk("hold_p", out_p, p);
         chk("hold_in_ready", 104'(in_ready), 104'(0));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("idle_in_ready", 104'(in_ready), 104'(1));
      chk("idle_out_valid", 104'(out_valid), 104'(0));
      chk("idle_busy", 104'(busy), 104'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [103:0] p;
      int           lat;
      realtime      t1, t2;
      int           cyc;
      logic [51:0]  ra, rb;

      vecs.push_back('{52'h1, 52'h1, 104'h1, 0});
      vecs.push_back('{MAX52, MAX52, 104'hFFFFFFFFFFFFE0000000000001, 0});
      vecs.push_back('{52'h4000000, 52'h3, 104'hC000000, 0});
      vecs.push_back('{52'h5, 52'h7, 104'h23, 1});
      vecs.push_back('{52'h3FFFFFF, 52'h3FFFFFF, 104'hFFFFFF8000001, 2});
      vecs.push_back('{52'h4000000, 52'h4000000, 104'h10000000000000, 0});
      vecs.push_back('{52'h0, MAX52, 104'h0, 1});
      vecs.push_back('{MAX52, 52'h1, 104'hFFFFFFFFFFFFF, 0});
      vecs.push_back('{52'h123456789ABCD, 52'h2, 104'h2468ACF13579A, 5});

      // Power-on reset
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 104'(out_valid), 104'(0));
      chk("rst_busy", 104'(busy), 104'(0));
      chk("rst_out_p", out_p, 104'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 104'(in_ready), 104'(1));
      chk("post_rst_out_valid", 104'(out_valid), 104'(0));

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].hold, p, lat, t1);
         chk($sformatf("vec%0d_p", i), p, vecs[i].p);
         chk($sformatf("vec%0d_latency", i), 104'(lat), 104'(6));
      end

      // Back-to-back issue with out_ready high: one acceptance every 7 cycles
      run_op(52'hABCDE, 52'h12345, 0, p, lat, t1);
      chk("b2b_first_p", p, ref_mul(52'hABCDE, 52'h12345));
      run_op(MAX52, 52'h4000000, 0, p, lat, t2);
      chk("b2b_second_p", p, ref_mul(MAX52, 52'h4000000));
      chk("issue_interval", 104'(int'((t2 - t1) / 10.0)), 104'(7));

      // Reset pulsed in cycle 3 of an operation
      in_valid = 1'b1;
      in_a     = MAX52;
      in_b     = MAX52;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (cyc < 3) begin
         @(posedge clk); #1;
         cyc++;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 104'(out_valid), 104'(0));
      chk("midrst_busy", 104'(busy), 104'(0));
      chk("midrst_out_p", out_p, 104'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_in_ready", 104'(in_ready), 104'(1));
      chk("midrst_idle_valid", 104'(out_valid), 104'(0));
      run_op(52'h5, 52'h7, 0, p, lat, t1);
      chk("after_rst_p", p, 104'h23);
      chk("after_rst_latency", 104'(lat), 104'(6));

      // Randomized operands, random consumer stalls
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 7))
            0:       ra = MAX52;
            1:       ra = 52'($urandom_range(0, 3)) << (26 * $urandom_range(0, 1));
            default: ra = rand52();
         endcase
         case ($urandom_range(0, 7))
            0:       rb = MAX52;
            1:       rb = 52'($urandom_range(0, 3)) << (26 * $urandom_range(0, 1));
            default: rb = rand52();
         endcase
         run_op(ra, rb, $urandom_range(0, 3), p, lat, t1);
         chk("rand_p", p, ref_mul(ra, rb));
         chk("rand_latency", 104'(lat), 104'(6));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
